// File: rtl/sa_result_drain.sv
// Drain stage behind the systolic-array core: snapshots all column results once every
// column is valid, acknowledges the core, then streams the words out column by column.
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int CNTW     = 16,
    localparam int PW      = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OUTWIDTH-1:0] in_r [0:ROWS-1],
    input  logic [0:ROWS-1]     in_v,
    output logic                outread,
    output logic [OUTWIDTH-1:0] m_data,
    output logic [PW-1:0]       m_col,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [CNTW-1:0]     frame_cnt,
    output logic                busy
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [OUTWIDTH-1:0]   buf_q [0:ROWS-1];
    logic [PW-1:0]         ptr_q;
    logic [CNTW-1:0]       cnt_q;
    logic                  outread_q;

    logic capture, hs, at_last;

    assign capture = (state_q == IDLE) && (&in_v);
    assign hs      = (state_q == DRAIN) && m_ready;
    assign at_last = (ptr_q == PW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture)      state_d = DRAIN;
            DRAIN:   if (hs && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by state so IDLE always shows a quiet, zeroed stream.
    always_comb begin
        m_valid = (state_q == DRAIN);
        busy    = (state_q == DRAIN);
        m_col   = m_valid ? ptr_q : '0;
        m_data  = m_valid ? buf_q[ptr_q] : '0;
        m_last  = m_valid && at_last;
    end

    assign outread   = outread_q;
    assign frame_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROWS; k++) buf_q[k] <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            outread_q <= 1'b0;
        end else begin
            outread_q <= capture;
            if (capture) begin
                for (int k = 0; k < ROWS; k++) buf_q[k] <= in_r[k];
                ptr_q <= '0;
            end else if (hs) begin
                if (at_last) cnt_q <= cnt_q + 1'b1;
                else         ptr_q <= ptr_q + 1'b1;
            end
        end
    end

endmodule
